// File: rtl/seq_nonrestoring_divider.sv
// Multi-cycle non-restoring integer divider producing one quotient bit per clock.
// Supports signed/unsigned operands, start/done handshake and divide-by-zero reporting.
module seq_nonrestoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             signedMode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    // state    | meaning
    // ST_IDLE  | waiting for start; results held
    // ST_ITER  | one non-restoring step per cycle, WIDTH steps
    // ST_FIX   | remainder correction, sign fix-up, publish results
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    cnt;
    logic             q_neg;
    logic             r_neg;
    logic             dz_pend;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   acc_sh;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign dvd_mag = (signedMode && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag = (signedMode && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The add/subtract choice uses the sign of A before the shift: the shifted value
    // may wrap in WIDTH+1 bits, but the step result always fits and comes out exact.
    assign acc_sh = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
    assign m_ext  = {1'b0, m_reg};
    assign acc_nx = acc[WIDTH] ? (acc_sh + m_ext) : (acc_sh - m_ext);

    // A negative final A lies in [-M, 0), so the low WIDTH bits plus M give the exact remainder.
    assign rem_mag = acc[WIDTH] ? (acc[WIDTH-1:0] + m_reg) : acc[WIDTH-1:0];
    assign q_fix   = q_neg ? -q_reg : q_reg;
    assign r_fix   = r_neg ? -rem_mag : rem_mag;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            acc       <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dz_pend   <= 1'b0;
            done      <= 1'b0;
            divByZero <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        cnt     <= CW'(WIDTH);
                        m_reg   <= dvs_mag;
                        q_neg   <= signedMode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg   <= signedMode & dividend[WIDTH-1];
                        dz_pend <= (divisor == '0);
                        // On divide-by-zero Q keeps the raw dividend to become the remainder.
                        if (divisor == '0) begin
                            q_reg <= dividend;
                            state <= ST_FIX;
                        end else begin
                            q_reg <= dvd_mag;
                            state <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    acc   <= acc_nx;
                    q_reg <= {q_reg[WIDTH-2:0], ~acc_nx[WIDTH]};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    done      <= 1'b1;
                    divByZero <= dz_pend;
                    state     <= ST_IDLE;
                    if (dz_pend) begin
                        quotient  <= '1;
                        remainder <= q_reg;
                    end else begin
                        quotient  <= q_fix;
                        remainder <= r_fix;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_nonrestoring_divider.md
# seq_nonrestoring_divider

Parametrised, multi-cycle non-restoring integer divider: one quotient bit per clock, with start/done handshake, signed and unsigned modes, and divide-by-zero reporting. It is the registered successor to our combinational divider. The ALU issues it long-latency DIV/REM operations and stalls on `busy`, which frees the datapath from a WIDTH-deep combinational chain.

## Interface
- `WIDTH`, default 32: operand and result width in bits, minimum 4.
- `clock` input 1: sole clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: request a divide. Sampled only while `busy`=0.
- `signedMode` input 1: 1 = two's-complement operands, 0 = unsigned. Sampled with `start`.
- `dividend` input WIDTH: numerator. Sampled with `start`.
- `divisor` input WIDTH: denominator. Sampled with `start`.
- `busy` output 1: operation in progress; new `start` is ignored.
- `done` output 1: single-cycle pulse when results update.
- `divByZero` output 1: the last operation had `divisor`=0. Held with the results.
- `quotient` output WIDTH: registered quotient, held until the next `done`.
- `remainder` output WIDTH: registered remainder, held until the next `done`.

## Operation
- States: IDLE, ITER, FIX.
- **IDLE + start:**
  - Capture operands. In signed mode store magnitudes |dividend| and |divisor| as WIDTH-bit unsigned values; |-2^(WIDTH-1)| = 2^(WIDTH-1) fits.
  - Latch `qNeg` = signs differ, and `rNeg` = dividend negative (both 0 in unsigned mode).
  - Clear accumulator A. Load bit counter = WIDTH.
  - Go to ITER, or to FIX directly with the zero flag set if `divisor`=0.
- **Accumulator width:** A is WIDTH+1 bits, with a sign bit beyond the operand width, so unsigned divisors ≥ 2^(WIDTH-1) never corrupt the sign test.
- **ITER, one step per cycle:**
  - Shift {A,Q} left by 1.
  - If A ≥ 0, A = A − M; else A = A + M. M is zero-extended to WIDTH+1 bits.
  - Set Q[0] = ~A[WIDTH].
  - Decrement the counter. After the step that takes it to 0, go to FIX.
- **FIX:**
  - If A < 0, add M back to A.
  - Negate Q if `qNeg`. Negate A if `rNeg`.
  - Register the truncated (C-style) results to `quotient`/`remainder`. The remainder takes the dividend's sign.
  - Pulse `done`. Return to IDLE.
- **Divide by zero:** `quotient` = all ones, `remainder` = original dividend, `divByZero` = 1. Otherwise `divByZero` = 0.
- **Signed overflow** (−2^(WIDTH-1) / −1): `quotient` = −2^(WIDTH-1) (wraps), `remainder` = 0, no flag.
- **Operand stability:** inputs may change freely after the `start` edge; the block works only from captured copies.

## Timing
- **Reset values:** while `resetn`=0, all of `busy`, `done`, `divByZero`, `quotient` and `remainder` are 0, and the state is IDLE.
- **Reset mid-operation:** abort immediately. No `done` is generated and outputs return to 0.
- **Normal divide:**
  - `start` is sampled high at edge 0, and `busy`=1 from edge 0 through edge WIDTH+1.
  - ITER occupies edges 1..WIDTH and FIX executes at edge WIDTH+1.
  - After edge WIDTH+1, `done`=1 for one cycle, `busy`=0 and results are valid. Latency is WIDTH+1 cycles.
- **Divide by zero:**
  - FIX runs at edge 1.
  - `done` is high after edge 1, with latency 1.
- **Back-to-back:** `start` asserted in the cycle where `done`=1 is accepted, because `busy` is already 0 there. Its results appear WIDTH+1 edges later.
- **Ignored starts:** `start` while `busy`=1 is dropped silently and does not queue.
- **Result stability:** `quotient`, `remainder` and `divByZero` change only at the `done` edge or on reset.

## Test plan
- **Unsigned, WIDTH=32:** 100 / 7.
  - Expect `quotient`=14, `remainder`=2.
  - `done` exactly 33 cycles after the `start` edge; `busy` high for 33 cycles.
- **Unsigned large divisor, WIDTH=32:** 0xFFFFFFFF / 0x80000000.
  - Expect `quotient`=1, `remainder`=0x7FFFFFFF. This checks the extra accumulator sign bit.
- **Signed, WIDTH=8:**
  - −7/2 expects `quotient`=−3 (0xFD), `remainder`=−1 (0xFF).
  - 7/−2 expects `quotient`=0xFD, `remainder`=1.
  - −128/−1 expects `quotient`=0x80, `remainder`=0.
- **Divide by zero, WIDTH=8:** 0x5A / 0.
  - `done` 1 cycle after `start`.
  - Expect `quotient`=0xFF, `remainder`=0x5A, `divByZero`=1.
  - A following 9/3 returns 3 / 0 with `divByZero`=0.
- **Handshake:**
  - Pulse `start` again mid-operation: it is ignored, with one `done` and unchanged results.
  - Assert `start` during the `done` cycle: a second result arrives 33 cycles later.
- **Reset mid-op:** drop `resetn` at ITER step 10.
  - All outputs read 0 immediately and no `done` is generated.
  - After release, a 50/5 request yields 10 / 0.
